// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported RAM between the IF fetch, MEM load/store and debug ports.
//  Clock/reset: CPU_CLK rising edge, CPU_RST asynchronous active-high.
//  Requesters (if_*, mem_*, dbg_*): req held until the one-cycle ack; rdata registered, held after ack.
//  RAM side (ram_*): one ram_en strobe per access, read data sampled in the last ACCESS cycle.
//  Status: stall_if/stall_mem to the hazard unit, grant_owner (0 none, 1 IF, 2 MEM, 3 DBG).
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                CPU_CLK,
  input  logic                CPU_RST,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic [DATA_W/8-1:0] mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  input  logic                dbg_req,
  input  logic [DATA_W/8-1:0] dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                dbg_ack,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic [1:0]          grant_owner
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [1:0] OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_MEM = 2'd2, OWN_DBG = 2'd3;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic [1:0] owner, win;
  logic [CNT_W-1:0] cnt;
  logic rr_mem;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0] we_q;
  logic [DATA_W-1:0] wdata_q;
  logic act_if, act_mem, act_dbg, grant, first, last;
  assign if_ack  = state == RESP && owner == OWN_IF;
  assign mem_ack = state == RESP && owner == OWN_MEM;
  assign dbg_ack = state == RESP && owner == OWN_DBG;
  // An ack only exists in RESP, so masking with it excludes the channel being acked.
  always_comb begin
    act_if    = if_req & ~if_ack;
    act_mem   = mem_req & ~mem_ack;
    act_dbg   = dbg_req & ~dbg_ack;
    win       = act_dbg ? OWN_DBG :
                (act_mem & act_if) ? (rr_mem ? OWN_IF : OWN_MEM) :
                act_mem ? OWN_MEM : act_if ? OWN_IF : OWN_NONE;
    grant     = (state == IDLE || state == RESP) && win != OWN_NONE;
    first     = state == ACCESS && cnt == CNT_W'(MEM_LATENCY);
    last      = state == ACCESS && cnt == CNT_W'(1);
    state_nxt = grant ? ACCESS : last ? RESP : state == ACCESS ? ACCESS : IDLE;
  end
  assign ram_en      = first;
  assign ram_we      = first ? we_q : '0;
  assign ram_addr    = first ? addr_q : '0;
  assign ram_wdata   = first ? wdata_q : '0;
  assign grant_owner = state == IDLE ? OWN_NONE : owner;
  // Stalls are forced low while reset is held so every output is quiet during reset.
  assign stall_if    = ~CPU_RST & if_req & ~if_ack;
  assign stall_mem   = ~CPU_RST & ((mem_req & ~mem_ack) | grant_owner == OWN_DBG);
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      cnt       <= '0;
      rr_mem    <= 1'b0;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner   <= win;
        cnt     <= CNT_W'(MEM_LATENCY);
        addr_q  <= win == OWN_DBG ? dbg_addr : win == OWN_MEM ? mem_addr : if_addr;
        we_q    <= win == OWN_DBG ? dbg_we : win == OWN_MEM ? mem_we : '0;
        wdata_q <= win == OWN_DBG ? dbg_wdata : win == OWN_MEM ? mem_wdata : '0;
        if (win != OWN_DBG) rr_mem <= win == OWN_MEM;
      end else if (state == ACCESS) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (last && we_q == '0) begin
        if (owner == OWN_IF) if_rdata <= ram_rdata;
        if (owner == OWN_MEM) mem_rdata <= ram_rdata;
        if (owner == OWN_DBG) dbg_rdata <= ram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst, rst1, fill;
  always #5 clk = ~clk;
  logic if_req, mem_req, dbg_req, mem_req1;
  logic [31:0] if_addr, mem_addr, mem_wdata, dbg_addr, dbg_wdata, mem_addr1;
  logic [3:0] mem_we, dbg_we;
  logic [31:0] if_rdata, mem_rdata, dbg_rdata, ram_addr, ram_wdata, ram_rdata;
  logic if_ack, mem_ack, dbg_ack, ram_en, stall_if, stall_mem;
  logic [3:0] ram_we;
  logic [1:0] grant_owner;
  logic [31:0] if_rdata1, mem_rdata1, dbg_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
  logic if_ack1, mem_ack1, dbg_ack1, ram_en1, stall_if1, stall_mem1;
  logic [3:0] ram_we1;
  logic [1:0] grant_owner1;
  int errors = 0, checks = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
    .CPU_CLK(clk), .CPU_RST(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .grant_owner(grant_owner));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .CPU_CLK(clk), .CPU_RST(rst1),
    .if_req(1'b0), .if_addr(32'd0), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .mem_req(mem_req1), .mem_we(4'd0), .mem_addr(mem_addr1), .mem_wdata(32'd0),
    .mem_rdata(mem_rdata1), .mem_ack(mem_ack1),
    .dbg_req(1'b0), .dbg_we(4'd0), .dbg_addr(32'd0), .dbg_wdata(32'd0),
    .dbg_rdata(dbg_rdata1), .dbg_ack(dbg_ack1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1), .grant_owner(grant_owner1));

  // RAM stand-in: write on the strobe edge, read data held from the strobed address until the next strobe.
  logic [31:0] ram [0:63];
  logic [5:0] hold = 6'd0;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) ram[i] <= (i == 4) ? 32'h0000_0013 : $urandom;
    end else if (ram_en) begin
      hold <= ram_addr[7:2];
      for (int b = 0; b < 4; b++) if (ram_we[b]) ram[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end
  assign ram_rdata  = ram_en ? ram[ram_addr[7:2]] : ram[hold];
  assign ram_rdata1 = 32'hA5A5_0000 ^ {26'd0, ram_addr1[7:2]};

  task automatic clear_inputs();
    if_req = 0; mem_req = 0; dbg_req = 0; mem_req1 = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; dbg_addr = 0; dbg_wdata = 0; mem_addr1 = 0;
    mem_we = 0; dbg_we = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    checks += 3;
    if ({ram_en, if_ack, mem_ack, dbg_ack, stall_if, stall_mem} !== 6'd0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {ram_en, if_ack, mem_ack, dbg_ack, stall_if, stall_mem});
    end
    if (grant_owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", grant_owner); end
    if ({if_rdata, mem_rdata, dbg_rdata} !== 96'd0) begin
      errors++; $display("FAIL reset_rdata got %h %h %h exp 0", if_rdata, mem_rdata, dbg_rdata);
    end
    rst = 0; rst1 = 0;
  endtask

  task automatic test_fetch();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin if_req = 1; if_addr = 32'h10; end
      if (c == 4) if_req = 0;
      @(negedge clk);
      checks += 3;
      if (ram_en !== (c == 1)) begin errors++; $display("FAIL fetch_en c=%0d got %b exp %b", c, ram_en, c == 1); end
      if (if_ack !== (c == 3)) begin errors++; $display("FAIL fetch_ack c=%0d got %b exp %b", c, if_ack, c == 3); end
      if (stall_if !== (c <= 2)) begin errors++; $display("FAIL fetch_stall c=%0d got %b exp %b", c, stall_if, c <= 2); end
      if (c == 1) begin
        checks++;
        if (ram_addr !== 32'h10) begin errors++; $display("FAIL fetch_addr got %h exp 10", ram_addr); end
      end
      if (c == 3) begin
        checks++;
        if (if_rdata !== 32'h13) begin errors++; $display("FAIL fetch_data got %h exp 13", if_rdata); end
      end
    end
  endtask

  task automatic test_reset_midrun();
    @(posedge clk); #1;
    mem_req = 1; mem_addr = 32'h14; if_req = 1; if_addr = 32'h18;
    @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (if_rdata !== 32'h13) begin errors++; $display("FAIL mid_pre_data got %h exp 13", if_rdata); end
    if (ram_en !== 1'b1) begin errors++; $display("FAIL mid_pre_en got %b exp 1", ram_en); end
    if (grant_owner !== 2'd2) begin errors++; $display("FAIL mid_pre_owner got %0d exp 2", grant_owner); end
    #2 rst = 1;
    #1;
    checks += 3;
    if ({ram_en, if_ack, mem_ack, dbg_ack, stall_if, stall_mem} !== 6'd0) begin
      errors++; $display("FAIL mid_ctrl got %b exp 000000", {ram_en, if_ack, mem_ack, dbg_ack, stall_if, stall_mem});
    end
    if (grant_owner !== 2'd0) begin errors++; $display("FAIL mid_owner got %0d exp 0", grant_owner); end
    if ({if_rdata, mem_rdata, dbg_rdata} !== 96'd0) begin
      errors++; $display("FAIL mid_rdata got %h %h %h exp 0", if_rdata, mem_rdata, dbg_rdata);
    end
    clear_inputs();
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_rr_tie();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        for (int c = 0; c <= 4; c++) begin
          @(posedge clk); #1;
          if (c == 0) begin mem_req = 1; mem_addr = 32'h28; end
          if (c == 4) mem_req = 0;
          @(negedge clk);
          checks++;
          if (mem_ack !== (c == 3)) begin errors++; $display("FAIL solo_ack c=%0d got %b exp %b", c, mem_ack, c == 3); end
        end
      end
      begin
        logic [1:0] f, s, eo;
        f = (r == 0) ? 2'd2 : 2'd1;
        s = 2'd3 - f;
        for (int c = 0; c <= 7; c++) begin
          @(posedge clk); #1;
          if (c == 0) begin if_req = 1; if_addr = 32'h20; mem_req = 1; mem_addr = 32'h24; mem_we = 0; end
          if (c == 4) begin if (f == 2'd1) if_req = 0; else mem_req = 0; end
          if (c == 7) begin if (s == 2'd1) if_req = 0; else mem_req = 0; end
          @(negedge clk);
          eo = (c >= 1 && c <= 3) ? f : (c >= 4 && c <= 6) ? s : 2'd0;
          checks += 4;
          if (grant_owner !== eo) begin errors++; $display("FAIL tie%0d_owner c=%0d got %0d exp %0d", r, c, grant_owner, eo); end
          if (ram_en !== (c == 1 || c == 4)) begin errors++; $display("FAIL tie%0d_en c=%0d got %b", r, c, ram_en); end
          if (if_ack !== ((f == 2'd1) ? (c == 3) : (c == 6))) begin errors++; $display("FAIL tie%0d_ifack c=%0d got %b", r, c, if_ack); end
          if (mem_ack !== ((f == 2'd2) ? (c == 3) : (c == 6))) begin errors++; $display("FAIL tie%0d_memack c=%0d got %b", r, c, mem_ack); end
          if (if_ack) begin
            checks++;
            if (if_rdata !== ram[8]) begin errors++; $display("FAIL tie%0d_ifdata got %h exp %h", r, if_rdata, ram[8]); end
          end
          if (mem_ack) begin
            checks++;
            if (mem_rdata !== ram[9]) begin errors++; $display("FAIL tie%0d_memdata got %h exp %h", r, mem_rdata, ram[9]); end
          end
        end
      end
    end
  endtask

  task automatic test_dbg_priority();
    logic [31:0] dbg_exp;
    logic [1:0] eo;
    do_reset();
    dbg_exp = ram[12];
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        dbg_req = 1; dbg_addr = 32'h30; mem_req = 1; mem_addr = 32'h34; if_req = 1; if_addr = 32'h38;
      end
      if (c == 4) dbg_req = 0;
      if (c == 7) mem_req = 0;
      if (c == 10) if_req = 0;
      @(negedge clk);
      eo = (c >= 1 && c <= 3) ? 2'd3 : (c >= 4 && c <= 6) ? 2'd2 : (c >= 7 && c <= 9) ? 2'd1 : 2'd0;
      checks += 4;
      if (grant_owner !== eo) begin errors++; $display("FAIL dbg_owner c=%0d got %0d exp %0d", c, grant_owner, eo); end
      if ({dbg_ack, mem_ack, if_ack} !== {c == 3, c == 6, c == 9}) begin
        errors++; $display("FAIL dbg_acks c=%0d got %b", c, {dbg_ack, mem_ack, if_ack});
      end
      if (stall_mem !== (c <= 5)) begin errors++; $display("FAIL dbg_stall c=%0d got %b exp %b", c, stall_mem, c <= 5); end
      if (ram_en !== (c == 1 || c == 4 || c == 7)) begin errors++; $display("FAIL dbg_en c=%0d got %b", c, ram_en); end
    end
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin dbg_req = 1; dbg_we = 4'hF; dbg_addr = 32'h3C; dbg_wdata = $urandom; end
      if (c == 4) begin dbg_req = 0; dbg_we = 0; end
      @(negedge clk);
      checks += 3;
      if (stall_mem !== (c >= 1 && c <= 3)) begin errors++; $display("FAIL dbgw_stall c=%0d got %b", c, stall_mem); end
      if (dbg_ack !== (c == 3)) begin errors++; $display("FAIL dbgw_ack c=%0d got %b", c, dbg_ack); end
      if (ram_we !== ((c == 1) ? 4'hF : 4'h0)) begin errors++; $display("FAIL dbgw_we c=%0d got %h", c, ram_we); end
      if (c == 3) begin
        checks++;
        if (dbg_rdata !== dbg_exp) begin errors++; $display("FAIL dbgw_rdata got %h exp %h", dbg_rdata, dbg_exp); end
      end
    end
  endtask

  task automatic test_store();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin mem_req = 1; mem_we = 4'b0011; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; end
      if (c == 4) begin mem_req = 0; mem_we = 0; end
      @(negedge clk);
      checks += 3;
      if (ram_we !== ((c == 1) ? 4'b0011 : 4'b0000)) begin errors++; $display("FAIL store_we c=%0d got %b", c, ram_we); end
      if (mem_ack !== (c == 3)) begin errors++; $display("FAIL store_ack c=%0d got %b", c, mem_ack); end
      if (mem_rdata !== 32'd0) begin errors++; $display("FAIL store_rdata c=%0d got %h exp 0", c, mem_rdata); end
      if (c == 1) begin
        checks++;
        if ({ram_addr, ram_wdata} !== {32'h100, 32'hDEADBEEF}) begin
          errors++; $display("FAIL store_bus got %h %h exp 100 deadbeef", ram_addr, ram_wdata);
        end
      end
    end
    checks++;
    if (ram[0][15:0] !== 16'hBEEF) begin errors++; $display("FAIL store_ram got %h exp beef", ram[0][15:0]); end
  endtask

  task automatic test_abort();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin mem_req = 1; mem_addr = 32'h40; end
      if (c == 2) begin
        checks++;
        if (grant_owner !== 2'd2) begin errors++; $display("FAIL abort_pre got %0d exp 2", grant_owner); end
        rst = 1; mem_req = 0;
      end
      if (c == 3) rst = 0;
      @(negedge clk);
      if (c >= 2) begin
        checks += 2;
        if ({mem_ack, ram_en} !== 2'b00) begin errors++; $display("FAIL abort_ack c=%0d got %b exp 00", c, {mem_ack, ram_en}); end
        if (grant_owner !== 2'd0) begin errors++; $display("FAIL abort_owner c=%0d got %0d exp 0", c, grant_owner); end
      end
    end
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin mem_req = 1; mem_addr = 32'h44; end
      if (c == 4) mem_req = 0;
      @(negedge clk);
      checks++;
      if (mem_ack !== (c == 3)) begin errors++; $display("FAIL abort_next c=%0d got %b", c, mem_ack); end
      if (c == 3) begin
        checks++;
        if (mem_rdata !== ram[17]) begin errors++; $display("FAIL abort_data got %h exp %h", mem_rdata, ram[17]); end
      end
    end
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin mem_req1 = 1; mem_addr1 = 32'h40; end
      if (c == 1) begin
        checks++;
        if (ram_en1 !== 1'b1) begin errors++; $display("FAIL l1_pre_en got %b exp 1", ram_en1); end
        rst1 = 1; mem_req1 = 0;
      end
      if (c == 2) rst1 = 0;
      @(negedge clk);
      if (c >= 1) begin
        checks++;
        if ({mem_ack1, ram_en1, grant_owner1} !== 4'd0) begin
          errors++; $display("FAIL l1_abort c=%0d got %b exp 0000", c, {mem_ack1, ram_en1, grant_owner1});
        end
      end
    end
    for (int c = 0; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin mem_req1 = 1; mem_addr1 = 32'h44; end
      if (c == 3) mem_req1 = 0;
      @(negedge clk);
      checks += 2;
      if (mem_ack1 !== (c == 2)) begin errors++; $display("FAIL l1_ack c=%0d got %b", c, mem_ack1); end
      if (ram_en1 !== (c == 1)) begin errors++; $display("FAIL l1_en c=%0d got %b", c, ram_en1); end
      if (c == 2) begin
        checks++;
        if (mem_rdata1 !== 32'hA5A5_0011) begin errors++; $display("FAIL l1_data got %h exp a5a50011", mem_rdata1); end
      end
    end
  endtask

  // Model: one access at a time, each occupying MEM_LATENCY+1 cycles from grant to ack; the server
  // picks a new request whenever it has no job or is acking, never the channel it is acking.
  task automatic test_random();
    logic [31:0] refmem [0:63];
    logic rq [1:3];
    logic [31:0] ad [1:3], wd [1:3], exp_rd [1:3];
    logic [3:0] we [1:3];
    logic seen [1:3];
    logic rr_mem, job_rd;
    logic [31:0] ea, ewd, edata, got;
    logic [3:0] ewe;
    logic [2:0] exp_ackv;
    int job, ack_at, en_at, acking, win;
    do_reset();
    for (int i = 0; i < 64; i++) refmem[i] = ram[i];
    for (int ch = 1; ch <= 3; ch++) begin
      rq[ch] = 0; ad[ch] = 0; wd[ch] = 0; we[ch] = 0; seen[ch] = 0; exp_rd[ch] = 0;
    end
    rr_mem = 0; job = 0; ack_at = -1; en_at = -1; job_rd = 0;
    ea = 0; ewd = 0; ewe = 0; edata = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int ch = 1; ch <= 3; ch++) begin
        if (rq[ch] && seen[ch]) rq[ch] = 0;
        if (!rq[ch] && $urandom_range(0, 2) == 0) begin
          rq[ch] = 1;
          ad[ch] = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
          we[ch] = (ch == 1 || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          wd[ch] = $urandom;
        end else if (rq[ch] && job == ch) begin
          ad[ch] = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
          wd[ch] = $urandom;
        end
      end
      if_req = rq[1]; if_addr = ad[1];
      mem_req = rq[2]; mem_addr = ad[2]; mem_we = we[2]; mem_wdata = wd[2];
      dbg_req = rq[3]; dbg_addr = ad[3]; dbg_we = we[3]; dbg_wdata = wd[3];
      @(negedge clk);
      acking = (job != 0 && c == ack_at) ? job : 0;
      exp_ackv = (acking != 0) ? 3'(1 << (acking - 1)) : 3'd0;
      checks += 5;
      if ({dbg_ack, mem_ack, if_ack} !== exp_ackv) begin
        errors++; $display("FAIL rnd_ack c=%0d got %b exp %b", c, {dbg_ack, mem_ack, if_ack}, exp_ackv);
      end
      if (grant_owner !== 2'(job)) begin errors++; $display("FAIL rnd_owner c=%0d got %0d exp %0d", c, grant_owner, job); end
      if (ram_en !== (c == en_at)) begin errors++; $display("FAIL rnd_en c=%0d got %b exp %b", c, ram_en, c == en_at); end
      if (stall_if !== (rq[1] && acking != 1)) begin errors++; $display("FAIL rnd_stall_if c=%0d got %b", c, stall_if); end
      if (stall_mem !== ((rq[2] && acking != 2) || job == 3)) begin errors++; $display("FAIL rnd_stall_mem c=%0d got %b", c, stall_mem); end
      if (c == en_at) begin
        checks++;
        if ({ram_addr, ram_we} !== {ea, ewe} || (ewe != 0 && ram_wdata !== ewd)) begin
          errors++; $display("FAIL rnd_bus c=%0d got %h %h %h exp %h %h %h", c, ram_addr, ram_we, ram_wdata, ea, ewe, ewd);
        end
      end
      if (acking != 0) begin
        if (job_rd) exp_rd[acking] = edata;
        got = (acking == 1) ? if_rdata : (acking == 2) ? mem_rdata : dbg_rdata;
        checks++;
        if (got !== exp_rd[acking]) begin errors++; $display("FAIL rnd_rdata c=%0d ch=%0d got %h exp %h", c, acking, got, exp_rd[acking]); end
      end
      for (int ch = 1; ch <= 3; ch++) seen[ch] = (acking == ch);
      if (job == 0 || acking != 0) begin
        win = (rq[3] && acking != 3) ? 3 :
              (rq[1] && acking != 1 && rq[2] && acking != 2) ? (rr_mem ? 1 : 2) :
              (rq[2] && acking != 2) ? 2 : (rq[1] && acking != 1) ? 1 : 0;
        job = win;
        if (win != 0) begin
          ack_at = c + 3; en_at = c + 1;
          ea = ad[win]; ewe = (win == 1) ? 4'h0 : we[win]; ewd = wd[win];
          if (win != 3) rr_mem = (win == 2);
          job_rd = (ewe == 4'h0);
          if (job_rd) edata = refmem[ea[7:2]];
          else for (int b = 0; b < 4; b++) if (ewe[b]) refmem[ea[7:2]][8*b +: 8] = ewd[8*b +: 8];
        end
      end
    end
    clear_inputs();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    rst = 1; rst1 = 1; fill = 1;
    clear_inputs();
    test_reset();
    fill = 0;
    test_fetch();
    test_reset_midrun();
    test_rr_tie();
    test_dbg_priority();
    test_store();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
